nocpe_feeder1x2: RTL and testbench
==================================

# nocpe_feeder1x2

Upstream operand feeder for the 1x2 chained PE array (`nocpe1x2`).
- Accepts operand tuples (a0, a1, b) over a valid/ready stream and buffers them in a small FIFO.
- Drives the array's `a0`/`a1`/`b0` inputs with the one-cycle skew that PE1 needs, because `b` reaches PE1 one cycle after PE0.
- Marks vector boundaries. It pulses `done` when both accumulators `c0`/`c1` hold final dot products, then pulses `pe_clr` to zero them before the next vector.

## Interface
Parameters:
- DW, 16, operand width (matches PE input width).
- DEPTH, 4, FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream tuple valid.
- in_ready  out  1  feeder can accept a tuple.
- in_a0  in  DW  operand for PE0.
- in_a1  in  DW  operand for PE1.
- in_b  in  DW  shared operand, enters at PE0.
- in_last  in  1  tuple is the final element of its vector.
- a0  out  DW  to PE0 `a0`.
- a1  out  DW  to PE1 `a1` (skewed +1 cycle).
- b0  out  DW  to PE0 `b0`.
- pe_clr  out  1  one-cycle accumulator clear to the array (ORed with rst at the array).
- done  out  1  one-cycle pulse: `c0`/`c1` final this cycle.
- vec_len  out  16  elements in the completed vector (only with NOCPE_FEEDER_CNT_EN).

## Operation
- A push occurs when in_valid && in_ready; it stores {a0, a1, b, last} in the FIFO.
- in_ready = !full. It is registered-state derived, with no combinational path from in_valid.
- The FSM has four states: RUN, DRAIN, DONE, CLEAR. Reset enters RUN.
- **RUN**
  - A pop occurs each cycle the FIFO is non-empty.
  - A pop registers a0 ← e.a0, b0 ← e.b, a1_dly ← e.a1.
  - If the FIFO is empty, a0 and b0 are driven 0 and a1_dly ← 0. Zero operands leave the accumulators unchanged (bubble).
  - A pop of an entry with last=1 moves to DRAIN.
- **DRAIN** (1 cycle): no pop; a0 = b0 = 0; a1 carries the last entry's a1; then go to DONE.
- **DONE** (1 cycle): no pop; all operands 0; done = 1; then go to CLEAR.
- **CLEAR** (1 cycle): no pop; all operands 0; pe_clr = 1; then go to RUN.
- Output a1 is always the registered a1_dly. It equals the a1 of the entry popped on the previous cycle, or 0.
- Pushes continue during DRAIN, DONE and CLEAR until the FIFO is full.
- Simultaneous push and pop on a full FIFO: the push is refused because in_ready = 0. The pop proceeds.
- Simultaneous push and pop otherwise: the count is unchanged.
- Pointer arithmetic wraps modulo DEPTH. Occupancy is held in a counter that is log2(DEPTH)+1 bits wide.

## Timing
- Last element popped at cycle T:
  - Operands are visible at T.
  - c0 is final at T+1 (DRAIN).
  - c1 is final at T+2.
  - done is asserted at T+2.
  - pe_clr is asserted at T+3.
  - The earliest next pop is at T+4.
- Feeder latency: a tuple pushed at cycle t with an empty FIFO in RUN appears on a0/b0 at t+1 and on a1 at t+2.
- Reset values: a0 = a1 = b0 = 0, pe_clr = 0, done = 0, vec_len = 0, in_ready = 1 (FIFO empty), state RUN.
- Reset mid-vector: the FIFO is flushed, the partial vector is discarded, and no done is produced. The array is cleared by its own rst.
- Throughput: one element per cycle within a vector. Each vector costs 3 extra cycles (DRAIN, DONE, CLEAR).

## Configuration
- Macro: NOCPE_FEEDER_CNT_EN.
- **Defined**
  - Adds a 16-bit element counter. It increments on every RUN pop and saturates at 16'hFFFF.
  - vec_len ← count, and the counter is cleared at the DONE transition. vec_len is valid while done = 1 and holds until the next done.
- **Undefined**
  - The vec_len port and the counter are absent.
  - All other behaviour is identical.

## Structure
- Package `nocpe_pkg` holds:
  - the DW default constant;
  - the `feeder_state_t` enum {RUN, DRAIN, DONE, CLEAR};
  - the FIFO entry struct {a0, a1, b, last}.
- One sub-module: `nocpe_feeder_fifo`, a synchronous FIFO parameterised by entry type and DEPTH.
  - Ports: push, pop, full, empty, data in/out.
  - Pop is combinational read of the head.
- The FSM, skew register and counter live in the top.

## Test plan
- Single vector {(5,5,10,last)} into `nocpe1x2` → done pulse with c0 = 50, c1 = 50; pe_clr on the next cycle; both accumulators then 0.
- Two-element vector (5,5,10), (20,7,15,last) back-to-back → at done, c0 = 350 and c1 = 155. a1 observed as 5 then 7, each one cycle after its b0.
- Bubble: same two elements with in_valid low for 3 cycles between them → identical c0 = 350, c1 = 155; done delayed by exactly 3 cycles.
- Backpressure: push a 1-element vector, then 6 consecutive tuples of the next vector → in_ready drops when the FIFO holds 4 during DRAIN/DONE/CLEAR. No tuple is lost, and the second result matches the golden sum.
- Reset mid-vector: assert rst for 1 cycle after 2 of 4 elements → in_ready = 1, outputs 0, no done. A fresh vector (3,4,2,last) then yields c0 = 6, c1 = 8.
- With NOCPE_FEEDER_CNT_EN: a 5-element vector → vec_len = 5 at done. The next 1-element vector → vec_len = 1.

Source files
------------

// File: rtl/nocpe_pkg.sv
// Shared types for the nocpe 1x2 operand feeder: state encoding, FIFO entry and counter helper.
package nocpe_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        CLEAR = 2'd3
    } feeder_state_t;

    typedef struct packed {
        logic [DW_DEFAULT-1:0] a0;
        logic [DW_DEFAULT-1:0] a1;
        logic [DW_DEFAULT-1:0] b;
        logic                  last;
    } feeder_entry_t;

    // Element counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/nocpe_feeder_fifo.sv
// Synchronous FIFO with combinational head read; push on full and pop on empty are ignored.
module nocpe_feeder_fifo
    import nocpe_pkg::*;
#(
    parameter type T     = feeder_entry_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    T              mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r];

    // Storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= T'(0);
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/nocpe_feeder1x2.sv
// Operand feeder for the 1x2 chained PE array: FIFO, PE1 skew, vector-boundary sequencing.
// Optional vec_len output and element counter enabled by NOCPE_FEEDER_CNT_EN.
module nocpe_feeder1x2
    import nocpe_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a0,
    input  logic [DW-1:0] in_a1,
    input  logic [DW-1:0] in_b,
    input  logic          in_last,
    output logic [DW-1:0] a0,
    output logic [DW-1:0] a1,
    output logic [DW-1:0] b0,
    output logic          pe_clr,
    output logic          done
`ifdef NOCPE_FEEDER_CNT_EN
    ,
    output logic [CNT_W-1:0] vec_len
`endif
);

    typedef struct packed {
        logic [DW-1:0] a0;
        logic [DW-1:0] a1;
        logic [DW-1:0] b;
        logic          last;
    } entry_t;

    feeder_state_t state_r;
    logic [DW-1:0] a1_dly_r;
    entry_t        entry_in_s;
    entry_t        head_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;

    assign in_ready   = !full_s;
    assign push_s     = in_valid && !full_s;
    assign pop_s      = (state_r == RUN) && !empty_s;
    assign entry_in_s = '{a0: in_a0, a1: in_a1, b: in_b, last: in_last};

    nocpe_feeder_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (entry_in_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Vector FSM with registered operands; done/pe_clr lag their state so they line up with c1 final.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= RUN;
            a0       <= {DW{1'b0}};
            b0       <= {DW{1'b0}};
            a1       <= {DW{1'b0}};
            a1_dly_r <= {DW{1'b0}};
            done     <= 1'b0;
            pe_clr   <= 1'b0;
        end else begin
            done <= 1'b0;
            pe_clr <= 1'b0;
            a1 <= a1_dly_r;
            case (state_r)
                RUN: begin
                    if (pop_s) begin
                        a0       <= head_s.a0;
                        b0       <= head_s.b;
                        a1_dly_r <= head_s.a1;
                        state_r  <= head_s.last ? DRAIN : RUN;
                    end else begin
                        a0       <= {DW{1'b0}};
                        b0       <= {DW{1'b0}};
                        a1_dly_r <= {DW{1'b0}};
                        state_r  <= RUN;
                    end
                end
                DRAIN: begin
                    a0       <= {DW{1'b0}};
                    b0       <= {DW{1'b0}};
                    a1_dly_r <= {DW{1'b0}};
                    state_r  <= DONE;
                end
                DONE: begin
                    a0       <= {DW{1'b0}};
                    b0       <= {DW{1'b0}};
                    a1_dly_r <= {DW{1'b0}};
                    done     <= 1'b1;
                    state_r  <= CLEAR;
                end
                CLEAR: begin
                    a0       <= {DW{1'b0}};
                    b0       <= {DW{1'b0}};
                    a1_dly_r <= {DW{1'b0}};
                    pe_clr   <= 1'b1;
                    state_r  <= RUN;
                end
                default: begin
                    a0       <= {DW{1'b0}};
                    b0       <= {DW{1'b0}};
                    a1_dly_r <= {DW{1'b0}};
                    state_r  <= RUN;
                end
            endcase
        end
    end

`ifdef NOCPE_FEEDER_CNT_EN
    logic [CNT_W-1:0] cnt_r;

    // Element count per vector, published to vec_len together with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            vec_len <= {CNT_W{1'b0}};
        end else if (state_r == DONE) begin
            vec_len <= cnt_r;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            cnt_r <= sat_inc(cnt_r);
        end else begin
            cnt_r <= cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_nocpe_feeder1x2.sv
// Directed bench for nocpe_feeder1x2 with a behavioural 1x2 PE array and queue scoreboards.
module tb_nocpe_feeder1x2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a0 = 16'd0;
    logic [15:0] in_a1 = 16'd0;
    logic [15:0] in_b = 16'd0;
    logic        in_last = 1'b0;
    logic [15:0] a0, a1, b0;
    logic        pe_clr, done;
`ifdef NOCPE_FEEDER_CNT_EN
    logic [15:0] vec_len;
`endif

    nocpe_feeder1x2 #(.DW(16), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a0    (in_a0),
        .in_a1    (in_a1),
        .in_b     (in_b),
        .in_last  (in_last),
        .a0       (a0),
        .a1       (a1),
        .b0       (b0),
        .pe_clr   (pe_clr),
        .done     (done)
`ifdef NOCPE_FEEDER_CNT_EN
        ,
        .vec_len  (vec_len)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] b;
    } op_t;
    typedef struct {
        logic [31:0] c0;
        logic [31:0] c1;
        int          len;
    } res_t;

    op_t  opq[$];
    res_t resq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;
    bit   pend_v = 1'b0;
    logic [15:0] pend_a1 = 16'd0;
    bit   done_d = 1'b0;
    bit   clr_d = 1'b0;
    bit   saw_full = 1'b0;
    logic [31:0] g0 = 32'd0;
    logic [31:0] g1 = 32'd0;
    int   glen = 0;

    // Reference 1x2 array: b forwarded PE0 -> PE1 through one register.
    logic [31:0] c0 = 32'd0;
    logic [31:0] c1 = 32'd0;
    logic [15:0] b1 = 16'd0;
    always @(posedge clk) begin
        if (rst || pe_clr) begin
            c0 <= 32'd0;
            c1 <= 32'd0;
            b1 <= 16'd0;
        end else begin
            c0 <= c0 + 32'(a0) * 32'(b0);
            b1 <= b0;
            c1 <= c1 + 32'(a1) * 32'(b1);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: pops operand and result scoreboards as the DUT produces them.
    always @(negedge clk) begin
        bit   ok;
        op_t  e;
        res_t r;
        if (rst) begin
            done_d = 1'b0;
            clr_d  = 1'b0;
        end else begin
            if (!in_ready) saw_full = 1'b1;
            if (pend_v) begin
                chk("a1_skew", 64'(a1), 64'(pend_a1));
                pend_v = 1'b0;
            end
            if (b0 !== 16'd0) begin
                ok = (opq.size() != 0);
                chk("op_expected", 64'(ok), 64'd1);
                if (ok) begin
                    e = opq.pop_front();
                    chk("a0_out", 64'(a0), 64'(e.a0));
                    chk("b0_out", 64'(b0), 64'(e.b));
                    pend_a1 = e.a1;
                    pend_v  = 1'b1;
                end
            end
            if (done) begin
                ok = (resq.size() != 0);
                chk("done_expected", 64'(ok), 64'd1);
                if (ok) begin
                    r = resq.pop_front();
                    chk("c0_at_done", 64'(c0), 64'(r.c0));
                    chk("c1_at_done", 64'(c1), 64'(r.c1));
`ifdef NOCPE_FEEDER_CNT_EN
                    chk("vec_len", 64'(vec_len), 64'(r.len));
`endif
                end
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (done_d) chk("pe_clr_after_done", 64'(pe_clr), 64'd1);
            if (clr_d) begin
                chk("c0_cleared", 64'(c0), 64'd0);
                chk("c1_cleared", 64'(c1), 64'd0);
            end
            done_d = done;
            clr_d  = pe_clr;
        end
    end

    task automatic send(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] y, input logic l);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_a0 = x0;
        in_a1 = x1;
        in_b = y;
        in_last = l;
        for (int k = 0; k < 64; k++) begin
            acc = in_ready;
            if (acc) begin
                opq.push_back('{a0: x0, a1: x1, b: y});
                g0 = g0 + 32'(x0) * 32'(y);
                g1 = g1 + 32'(x1) * 32'(y);
                glen++;
                if (l) begin
                    resq.push_back('{c0: g0, c1: g1, len: glen});
                    g0 = 32'd0;
                    g1 = 32'd0;
                    glen = 0;
                end
            end
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) chk("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string tag);
        int start = done_cnt;
        for (int k = 0; k < 60; k++) begin
            if (done_cnt > start) break;
            @(posedge clk);
            #1;
        end
        chk(tag, 64'(done_cnt > start), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d2, d3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a0", 64'(a0), 64'd0);
        chk("rst_a1", 64'(a1), 64'd0);
        chk("rst_b0", 64'(b0), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pe_clr", 64'(pe_clr), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef NOCPE_FEEDER_CNT_EN
        chk("rst_vec_len", 64'(vec_len), 64'd0);
`endif
        rst = 1'b0;
        idle(2);

        // Single element vector: c0 = c1 = 50.
        send(16'd5, 16'd5, 16'd10, 1'b1);
        idle(1);
        wait_done("done_single");
        idle(4);

        // Two elements back-to-back: c0 = 350, c1 = 155.
        t0 = cyc;
        send(16'd5, 16'd5, 16'd10, 1'b0);
        send(16'd20, 16'd7, 16'd15, 1'b1);
        idle(1);
        wait_done("done_pair");
        d2 = last_done_cyc - t0;
        idle(4);

        // Same pair with a 3-cycle bubble in between.
        t0 = cyc;
        send(16'd5, 16'd5, 16'd10, 1'b0);
        idle(3);
        send(16'd20, 16'd7, 16'd15, 1'b1);
        idle(1);
        wait_done("done_bubble");
        d3 = last_done_cyc - t0;
        chk("bubble_delay", 64'(d3), 64'(d2 + 3));
        idle(4);

        // Backpressure: next vector queues up during DRAIN/DONE/CLEAR.
        saw_full = 1'b0;
        send(16'd3, 16'd9, 16'd2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            send(16'($urandom_range(1, 200)), 16'($urandom_range(1, 200)),
                 16'($urandom_range(1, 200)), (i == 5) ? 1'b1 : 1'b0);
        end
        idle(1);
        wait_done("done_bp");
        chk("saw_backpressure", 64'(saw_full), 64'd1);
        idle(4);

        // Reset mid-vector with one element still queued.
        send(16'd1, 16'd2, 16'd3, 1'b0);
        send(16'd4, 16'd5, 16'd6, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        opq.delete();
        pend_v = 1'b0;
        g0 = 32'd0;
        g1 = 32'd0;
        glen = 0;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_a0", 64'(a0), 64'd0);
        chk("mid_rst_a1", 64'(a1), 64'd0);
        chk("mid_rst_b0", 64'(b0), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        idle(6);
        send(16'd3, 16'd4, 16'd2, 1'b1);
        idle(1);
        wait_done("done_after_rst");
        idle(4);

        // Five-element vector followed by a single-element vector.
        for (int i = 1; i <= 5; i++) begin
            send(16'(i), 16'(i + 10), 16'(2 * i), (i == 5) ? 1'b1 : 1'b0);
        end
        send(16'd7, 16'd8, 16'd9, 1'b1);
        idle(1);
        wait_done("done_len5");
        wait_done("done_len1");
        idle(10);

        chk("ops_drained", 64'(opq.size()), 64'd0);
        chk("results_drained", 64'(resq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
